// File: rtl/popcount_voter.sv
// popcount_voter: accumulates the 1 bits of DEPTH words per frame and emits a count plus a mode-selected decision bit
module popcount_voter #(
  parameter int WIDTH = 7,
  parameter int DEPTH = 4,
  localparam int CW = $clog2(WIDTH * DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       mode,
  input  logic [CW-1:0]    thresh,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_bit,
  output logic [CW-1:0]    out_count
);
  localparam int NW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int TOT = WIDTH * DEPTH;
  typedef enum logic {ACC, OUT} state_t;
  state_t state, state_nxt;
  logic [NW-1:0] cnt;
  logic [CW-1:0] acc, pc, sum, thresh_r, th_eff;
  logic [1:0] mode_r, mode_eff;
  logic live, take, first, last, dec;
  // live holds in_ready low until the first edge after reset release
  assign in_ready = live && state == ACC;
  assign out_valid = state == OUT;
  assign take = in_valid && in_ready;
  assign first = cnt == '0;
  assign last = cnt == NW'(DEPTH - 1);
  assign sum = acc + pc;
  // population count of the incoming word
  always_comb begin
    pc = '0;
    for (int i = 0; i < WIDTH; i++) pc = pc + CW'(in_data[i]);
  end
  // word 0 decides with the live mode/thresh since the registered copies load on the same edge
  always_comb begin
    mode_eff = first ? mode : mode_r;
    th_eff = first ? thresh : thresh_r;
    dec = mode_eff == 2'b00 ? {sum, 1'b0} > (CW + 1)'(TOT) :
          mode_eff == 2'b01 ? sum[0] :
          mode_eff == 2'b10 ? sum >= th_eff : sum != '0;
  end
  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ACC;
    else state <= state_nxt;
  end
  // next state: leave ACC on the last word, leave OUT on the result handshake
  always_comb begin
    state_nxt = state;
    if (state == ACC) state_nxt = take && last ? OUT : ACC;
    else state_nxt = out_ready ? ACC : OUT;
  end
  // accumulator, word counter, per-frame settings and held result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      live <= 1'b0;
      acc <= '0;
      cnt <= '0;
      mode_r <= '0;
      thresh_r <= '0;
      out_bit <= 1'b0;
      out_count <= '0;
    end else begin
      live <= 1'b1;
      if (state == OUT) begin
        if (out_ready) begin
          acc <= '0;
          cnt <= '0;
        end
      end else if (take) begin
        acc <= sum;
        cnt <= last ? '0 : cnt + NW'(1);
        if (first) begin
          mode_r <= mode;
          thresh_r <= thresh;
        end
        if (last) begin
          out_count <= sum;
          out_bit <= dec;
        end
      end
    end
  end
endmodule

// File: tb/tb_popcount_voter.sv
// tb_popcount_voter: directed checks of the frame popcount voter at WIDTH=7/DEPTH=4 plus a DEPTH=1 instance
module tb_popcount_voter;
  logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [6:0] in_data = '0;
  logic [1:0] mode = '0;
  logic [4:0] thresh = '0;
  logic in_ready, out_valid, out_bit;
  logic [4:0] out_count;
  logic v1 = 1'b0, oready1 = 1'b0, rdy1, ovalid1, obit1;
  logic [6:0] data1 = '0;
  logic [1:0] mode1 = '0;
  logic [2:0] th1 = '0, ocnt1;
  int total = 0, passed = 0;

  popcount_voter #(.WIDTH(7), .DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .mode(mode), .thresh(thresh), .out_valid(out_valid), .out_ready(out_ready),
    .out_bit(out_bit), .out_count(out_count)
  );

  popcount_voter #(.WIDTH(7), .DEPTH(1)) d1 (
    .clk(clk), .rst_n(rst_n), .in_valid(v1), .in_ready(rdy1), .in_data(data1),
    .mode(mode1), .thresh(th1), .out_valid(ovalid1), .out_ready(oready1),
    .out_bit(obit1), .out_count(ocnt1)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic [6:0] d, input logic [1:0] m, input logic [4:0] t);
    @(negedge clk);
    in_valid = 1'b1;
    in_data = d;
    mode = m;
    thresh = t;
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic frame(input logic [6:0] a, b, c, d, input logic [1:0] m, input logic [4:0] t);
    drive(a, m, t);
    drive(b, m, t);
    drive(c, m, t);
    drive(d, m, t);
    idle();
  endtask

  task automatic take();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    total++; if (in_ready !== 1'b0) $display("FAIL rst_in_ready got %b want 0", in_ready); else passed++;
    total++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid got %b want 0", out_valid); else passed++;
    total++; if (out_count !== 5'd0 || out_bit !== 1'b0) $display("FAIL rst_outputs got %0d/%b want 0/0", out_count, out_bit); else passed++;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    total++; if (in_ready !== 1'b1) $display("FAIL rst_release_ready got %b want 1", in_ready); else passed++;
  endtask

  task automatic test_majority();
    frame(7'h7F, 7'h7F, 7'h7F, 7'h7F, 2'b00, 5'd0);
    total++; if (out_valid !== 1'b1 || in_ready !== 1'b0) $display("FAIL maj_latency got v=%b r=%b want v=1 r=0", out_valid, in_ready); else passed++;
    total++; if (out_count !== 5'd28 || out_bit !== 1'b1) $display("FAIL maj_all got %0d/%b want 28/1", out_count, out_bit); else passed++;
    take();
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) $display("FAIL maj_handshake got v=%b r=%b want v=0 r=1", out_valid, in_ready); else passed++;
    total++; if (out_count !== 5'd28 || out_bit !== 1'b1) $display("FAIL maj_hold got %0d/%b want 28/1", out_count, out_bit); else passed++;
    frame(7'h55, 7'h55, 7'h55, 7'h55, 2'b00, 5'd0);
    total++; if (out_count !== 5'd16 || out_bit !== 1'b1) $display("FAIL maj_alt got %0d/%b want 16/1", out_count, out_bit); else passed++;
    take();
    frame(7'h00, 7'h00, 7'h00, 7'h00, 2'b00, 5'd0);
    total++; if (out_count !== 5'd0 || out_bit !== 1'b0) $display("FAIL maj_zero got %0d/%b want 0/0", out_count, out_bit); else passed++;
    take();
    frame(7'h7F, 7'h7F, 7'h00, 7'h00, 2'b00, 5'd0);
    total++; if (out_count !== 5'd14 || out_bit !== 1'b0) $display("FAIL maj_tie got %0d/%b want 14/0", out_count, out_bit); else passed++;
    take();
  endtask

  task automatic test_parity();
    frame(7'h78, 7'h2A, 7'h14, 7'h01, 2'b01, 5'd0);
    total++; if (out_count !== 5'd10 || out_bit !== 1'b0) $display("FAIL par_even got %0d/%b want 10/0", out_count, out_bit); else passed++;
    take();
    frame(7'h78, 7'h2A, 7'h14, 7'h03, 2'b01, 5'd0);
    total++; if (out_count !== 5'd11 || out_bit !== 1'b1) $display("FAIL par_odd got %0d/%b want 11/1", out_count, out_bit); else passed++;
    take();
  endtask

  task automatic test_threshold();
    frame(7'h7F, 7'h7F, 7'h00, 7'h00, 2'b10, 5'd14);
    total++; if (out_count !== 5'd14 || out_bit !== 1'b1) $display("FAIL thr_equal got %0d/%b want 14/1", out_count, out_bit); else passed++;
    take();
    frame(7'h7F, 7'h7E, 7'h00, 7'h00, 2'b10, 5'd14);
    total++; if (out_count !== 5'd13 || out_bit !== 1'b0) $display("FAIL thr_below got %0d/%b want 13/0", out_count, out_bit); else passed++;
    take();
    drive(7'h7F, 2'b10, 5'd14);
    drive(7'h7E, 2'b10, 5'd14);
    drive(7'h00, 2'b11, 5'd0);
    drive(7'h00, 2'b11, 5'd0);
    idle();
    total++; if (out_count !== 5'd13 || out_bit !== 1'b0) $display("FAIL thr_late_change got %0d/%b want 13/0", out_count, out_bit); else passed++;
    take();
  endtask

  task automatic test_backpressure();
    frame(7'h7F, 7'h7F, 7'h7F, 7'h7F, 2'b00, 5'd0);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data = 7'h7F;
      @(negedge clk);
      total++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_count !== 5'd28 || out_bit !== 1'b1)
        $display("FAIL bp_hold%0d got v=%b r=%b %0d/%b want v=1 r=0 28/1", i, out_valid, in_ready, out_count, out_bit);
      else passed++;
    end
    in_valid = 1'b0;
    take();
    drive(7'h55, 2'b00, 5'd0);
    idle();
    drive(7'h55, 2'b00, 5'd0);
    idle();
    idle();
    drive(7'h55, 2'b00, 5'd0);
    idle();
    total++; if (out_valid !== 1'b0) $display("FAIL gap_early got v=%b want 0", out_valid); else passed++;
    drive(7'h55, 2'b00, 5'd0);
    idle();
    total++; if (out_valid !== 1'b1 || out_count !== 5'd16 || out_bit !== 1'b1) $display("FAIL gap_sum got v=%b %0d/%b want v=1 16/1", out_valid, out_count, out_bit); else passed++;
    take();
  endtask

  task automatic test_reset_mid();
    drive(7'h7F, 2'b00, 5'd0);
    drive(7'h7F, 2'b00, 5'd0);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    total++; if (out_count !== 5'd0 || out_bit !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b0)
      $display("FAIL mid_rst got v=%b r=%b %0d/%b want v=0 r=0 0/0", out_valid, in_ready, out_count, out_bit); else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    frame(7'h78, 7'h2A, 7'h14, 7'h01, 2'b00, 5'd0);
    total++; if (out_valid !== 1'b1 || out_count !== 5'd10 || out_bit !== 1'b0) $display("FAIL mid_fresh got v=%b %0d/%b want v=1 10/0", out_valid, out_count, out_bit); else passed++;
    take();
  endtask

  task automatic test_depth1();
    @(negedge clk);
    v1 = 1'b1;
    data1 = 7'h78;
    mode1 = 2'b00;
    @(negedge clk);
    v1 = 1'b0;
    total++; if (ovalid1 !== 1'b1 || ocnt1 !== 3'd4 || obit1 !== 1'b1) $display("FAIL d1_result got v=%b %0d/%b want v=1 4/1", ovalid1, ocnt1, obit1); else passed++;
    oready1 = 1'b1;
    @(negedge clk);
    oready1 = 1'b0;
    total++; if (ovalid1 !== 1'b0 || rdy1 !== 1'b1) $display("FAIL d1_handshake got v=%b r=%b want v=0 r=1", ovalid1, rdy1); else passed++;
  endtask

  initial begin
    test_reset();
    test_majority();
    test_parity();
    test_threshold();
    test_backpressure();
    test_reset_mid();
    test_depth1();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
